conv_processor_gen: RTL and testbench

- Parametrised successor to the fixed 8-bit/6-bit convolution core.
- Computes the 1-D discrete convolution Z = X * Y from two synchronous-read input memories and writes results to an output memory.
- Supports run-time full/valid modes, signed/unsigned operands, and independent X and Y lengths, with saturating output.
- Sits behind the AIP interface wrapper. Start, sizes and mode come from config registers; busy and done feed the status and interrupt bits.

---
 rtl/conv_processor_gen.sv | 187 ++++++++++++++++++
 tb/tb_conv_processor_gen.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_processor_gen.sv
// Parametrised 1-D convolution engine: Z = X * Y read from synchronous memories,
// with full/valid modes, signed/unsigned operands and saturating results.
module conv_processor_gen #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 6,
    parameter int OUT_W  = 16,
    parameter int ACC_W  = 2*DATA_W+ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              mode_i,
    input  logic              signed_i,
    input  logic [ADDR_W-1:0] sizeX_i,
    input  logic [ADDR_W-1:0] sizeY_i,
    output logic [ADDR_W-1:0] memXaddr_o,
    input  logic [DATA_W-1:0] dataX_i,
    output logic [ADDR_W-1:0] memYaddr_o,
    input  logic [DATA_W-1:0] dataY_i,
    output logic [ADDR_W:0]   memZaddr_o,
    output logic [OUT_W-1:0]  dataZ_o,
    output logic              writeZ_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              sat_o
);

    typedef enum logic [2:0] {IDLE, INIT, READ, MAC, WRITE, DONE} state_t;

    localparam int PW = 2*DATA_W+2;
    localparam logic [ADDR_W-1:0]       ONE_A  = ADDR_W'(1);
    localparam logic [ADDR_W:0]         ONE_N  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0]         TWO_N  = (ADDR_W+1)'(2);
    localparam logic signed [ACC_W:0]   ONE_C  = (ACC_W+1)'(1);
    localparam logic signed [ACC_W:0]   U_MAX  = (ONE_C <<< OUT_W) - ONE_C;
    localparam logic signed [ACC_W:0]   S_MAX  = (ONE_C <<< (OUT_W-1)) - ONE_C;
    localparam logic signed [ACC_W:0]   S_MIN  = -(ONE_C <<< (OUT_W-1));
    localparam logic [OUT_W-1:0]        Z_UMAX = '1;
    localparam logic [OUT_W-1:0]        Z_SMAX = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0]        Z_SMIN = {1'b1, {(OUT_W-1){1'b0}}};

    state_t state, state_next;

    logic [ADDR_W-1:0]     size_x, size_y;
    logic                  mode_r, signed_r;
    logic [ADDR_W:0]       n;
    logic [ADDR_W-1:0]     k;
    // One bit wider than ACC_W so an unsigned full-length sum stays positive.
    logic signed [ACC_W:0] acc;
    logic [ADDR_W-1:0]     addr_x, addr_y;
    logic [ADDR_W:0]       z_addr;
    logic [OUT_W-1:0]      z_data;
    logic                  sat_r;

    logic [ADDR_W-1:0]     off;
    logic [ADDR_W:0]       m;
    logic [ADDR_W-1:0]     k_lo, k_hi;
    logic [ADDR_W:0]       last_n;
    logic                  degenerate;
    logic signed [PW-1:0]  ext_x, ext_y, prod;
    logic signed [ACC_W:0] acc_next;
    logic [OUT_W-1:0]      sat_val;
    logic                  clamp;

    assign off        = mode_r ? (size_y - ONE_A) : '0;
    assign m          = n + {1'b0, off};
    assign k_lo       = (m >= {1'b0, size_y}) ? (m[ADDR_W-1:0] - size_y + ONE_A) : '0;
    assign k_hi       = (m < {1'b0, size_x}) ? m[ADDR_W-1:0] : (size_x - ONE_A);
    assign last_n     = mode_r ? ({1'b0, size_x} - {1'b0, size_y})
                               : ({1'b0, size_x} + {1'b0, size_y} - TWO_N);
    assign degenerate = (size_x == '0) || (size_y == '0) || (mode_r && (size_y > size_x));

    always_comb begin
        ext_x    = signed_r ? {{(DATA_W+2){dataX_i[DATA_W-1]}}, dataX_i}
                            : {{(DATA_W+2){1'b0}}, dataX_i};
        ext_y    = signed_r ? {{(DATA_W+2){dataY_i[DATA_W-1]}}, dataY_i}
                            : {{(DATA_W+2){1'b0}}, dataY_i};
        prod     = ext_x * ext_y;
        acc_next = acc + {{(ACC_W+1-PW){prod[PW-1]}}, prod};
        sat_val  = acc_next[OUT_W-1:0];
        clamp    = 1'b0;
        if (signed_r) begin
            if (acc_next > S_MAX) begin
                sat_val = Z_SMAX;
                clamp   = 1'b1;
            end else if (acc_next < S_MIN) begin
                sat_val = Z_SMIN;
                clamp   = 1'b1;
            end
        end else if (acc_next > U_MAX) begin
            sat_val = Z_UMAX;
            clamp   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Degenerate sizes are judged in INIT from the latched values, so such runs
    // still spend one busy cycle before DONE.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_i) state_next = INIT;
            INIT:    state_next = degenerate ? DONE : READ;
            READ:    state_next = MAC;
            MAC:     state_next = (k == k_hi) ? WRITE : READ;
            WRITE:   state_next = (n == last_n) ? DONE : INIT;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        writeZ_o = (state == WRITE);
        done_o   = (state == DONE);
        busy_o   = (state == INIT) || (state == READ) || (state == MAC) || (state == WRITE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            size_x   <= '0;
            size_y   <= '0;
            mode_r   <= 1'b0;
            signed_r <= 1'b0;
            n        <= '0;
            k        <= '0;
            acc      <= '0;
            addr_x   <= '0;
            addr_y   <= '0;
            z_addr   <= '0;
            z_data   <= '0;
            sat_r    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_i) begin
                        size_x   <= sizeX_i;
                        size_y   <= sizeY_i;
                        mode_r   <= mode_i;
                        signed_r <= signed_i;
                        sat_r    <= 1'b0;
                        n        <= '0;
                    end
                end
                INIT: begin
                    acc <= '0;
                    k   <= k_lo;
                    if (!degenerate) begin
                        addr_x <= k_lo;
                        addr_y <= m[ADDR_W-1:0] - k_lo;
                    end
                end
                MAC: begin
                    acc <= acc_next;
                    // Result and sticky flag are registered on the last tap so
                    // they are already stable during the write cycle.
                    if (k == k_hi) begin
                        z_addr <= n;
                        z_data <= sat_val;
                        if (clamp) sat_r <= 1'b1;
                    end else begin
                        k      <= k + ONE_A;
                        addr_x <= k + ONE_A;
                        addr_y <= m[ADDR_W-1:0] - k - ONE_A;
                    end
                end
                WRITE: begin
                    if (n != last_n) n <= n + ONE_N;
                end
                default: ;
            endcase
        end
    end

    assign memXaddr_o = addr_x;
    assign memYaddr_o = addr_y;
    assign memZaddr_o = z_addr;
    assign dataZ_o    = z_data;
    assign sat_o      = sat_r;

endmodule

// File: tb/tb_conv_processor_gen.sv
// Self-checking bench for conv_processor_gen: directed cases plus randomized runs
// compared against a direct summation model of the convolution.
module tb_conv_processor_gen;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 6;
    localparam int OUT_W  = 16;
    localparam int BUDGET = 12000;

    logic              clk = 1'b0;
    logic              rst;
    logic              start_i, mode_i, signed_i;
    logic [ADDR_W-1:0] sizeX_i, sizeY_i;
    logic [ADDR_W-1:0] memXaddr_o, memYaddr_o;
    logic [DATA_W-1:0] dataX_i, dataY_i;
    logic [ADDR_W:0]   memZaddr_o;
    logic [OUT_W-1:0]  dataZ_o;
    logic              writeZ_o, busy_o, done_o, sat_o;

    logic [DATA_W-1:0] mem_x [0:63];
    logic [DATA_W-1:0] mem_y [0:63];

    int checks = 0;
    int errors = 0;

    logic [ADDR_W:0]  obs_addr [$];
    logic [OUT_W-1:0] obs_data [$];
    logic             obs_satw [$];
    int               obs_cyc;
    logic             obs_busy_bad, obs_sat_done, obs_sat_after, obs_busy_after, obs_done_after;

    logic [OUT_W-1:0] exp_data [$];
    int               exp_cyc;
    logic             exp_sat;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        dataX_i <= mem_x[memXaddr_o];
        dataY_i <= mem_y[memYaddr_o];
    end

    conv_processor_gen dut (
        .clk(clk), .rst(rst), .start_i(start_i), .mode_i(mode_i), .signed_i(signed_i),
        .sizeX_i(sizeX_i), .sizeY_i(sizeY_i),
        .memXaddr_o(memXaddr_o), .dataX_i(dataX_i),
        .memYaddr_o(memYaddr_o), .dataY_i(dataY_i),
        .memZaddr_o(memZaddr_o), .dataZ_o(dataZ_o), .writeZ_o(writeZ_o),
        .busy_o(busy_o), .done_o(done_o), .sat_o(sat_o)
    );

    // Reference: direct sum over every (k, m-k) pair inside both sequences.
    task automatic model(input logic md, input logic sg, input int sx, input int sy);
        int len, off, sum, taps, xv, yv;
        exp_data.delete();
        exp_sat = 1'b0;
        if (sx == 0 || sy == 0 || (md && sy > sx)) begin
            exp_cyc = 2;
            return;
        end
        len = md ? sx - sy + 1 : sx + sy - 1;
        off = md ? sy - 1 : 0;
        exp_cyc = 1;
        for (int n = 0; n < len; n++) begin
            sum = 0;
            taps = 0;
            for (int kk = 0; kk < sx; kk++) begin
                if (n + off - kk >= 0 && n + off - kk < sy) begin
                    xv = sg ? int'($signed(mem_x[kk])) : int'(mem_x[kk]);
                    yv = sg ? int'($signed(mem_y[n + off - kk])) : int'(mem_y[n + off - kk]);
                    sum += xv * yv;
                    taps++;
                end
            end
            exp_cyc += 2 * taps + 2;
            if (sg && sum > 32767) begin sum = 32767; exp_sat = 1'b1; end
            else if (sg && sum < -32768) begin sum = -32768; exp_sat = 1'b1; end
            else if (!sg && sum > 65535) begin sum = 65535; exp_sat = 1'b1; end
            exp_data.push_back(16'(sum));
        end
    endtask

    // pulse_at > 0 pulses start_i at that cycle of the run; -2 pulses it during DONE.
    task automatic run_job(input logic md, input logic sg, input int sx, input int sy, input int pulse_at);
        obs_addr.delete();
        obs_data.delete();
        obs_satw.delete();
        obs_cyc = -1;
        obs_busy_bad = 1'b0;
        obs_sat_done = 1'b0;
        @(negedge clk);
        mode_i = md; signed_i = sg; sizeX_i = ADDR_W'(sx); sizeY_i = ADDR_W'(sy);
        start_i = 1'b1;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        sizeX_i = ADDR_W'($urandom); sizeY_i = ADDR_W'($urandom); mode_i = ~md; signed_i = ~sg;
        for (int c = 1; c <= BUDGET; c++) begin
            @(negedge clk);
            if (writeZ_o) begin
                obs_addr.push_back(memZaddr_o);
                obs_data.push_back(dataZ_o);
                obs_satw.push_back(sat_o);
            end
            if (done_o) begin
                obs_cyc = c;
                obs_sat_done = sat_o;
                start_i = (pulse_at == -2);
                break;
            end
            if (!busy_o) obs_busy_bad = 1'b1;
            start_i = (c == pulse_at);
        end
        @(negedge clk);
        start_i = 1'b0;
        obs_sat_after  = sat_o;
        obs_busy_after = busy_o;
        obs_done_after = done_o;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({memXaddr_o, memYaddr_o, memZaddr_o, dataZ_o, writeZ_o, busy_o, done_o, sat_o} !== '0)
            begin errors++; $display("[TB] FAIL reset_outputs: got x=%0h y=%0h z=%0h d=%0h w=%b b=%b dn=%b s=%b, want all 0",
                memXaddr_o, memYaddr_o, memZaddr_o, dataZ_o, writeZ_o, busy_o, done_o, sat_o); end
        rst = 1'b0;
    endtask

    task automatic test_full_unsigned;
        logic [OUT_W-1:0] want [4] = '{16'd1, 16'd3, 16'd5, 16'd3};
        mem_x[0] = 8'd1; mem_x[1] = 8'd2; mem_x[2] = 8'd3;
        mem_y[0] = 8'd1; mem_y[1] = 8'd1;
        run_job(1'b0, 1'b0, 3, 2, -1);
        checks++; if (obs_cyc !== 21) begin errors++; $display("[TB] FAIL full_done_cycle: got %0d, want 21", obs_cyc); end
        checks++; if (obs_data.size() !== 4) begin errors++; $display("[TB] FAIL full_write_count: got %0d, want 4", obs_data.size()); end
        for (int i = 0; i < 4 && i < obs_data.size(); i++) begin
            checks++;
            if (obs_addr[i] !== 7'(i) || obs_data[i] !== want[i]) begin errors++;
                $display("[TB] FAIL full_z%0d: got Z[%0d]=%0h, want Z[%0d]=%0h", i, obs_addr[i], obs_data[i], i, want[i]); end
        end
        checks++; if (obs_busy_bad !== 1'b0) begin errors++; $display("[TB] FAIL full_busy: busy dropped before done"); end
        checks++; if (obs_sat_done !== 1'b0) begin errors++; $display("[TB] FAIL full_sat: got %b, want 0", obs_sat_done); end
        checks++; if (obs_done_after !== 1'b0 || obs_busy_after !== 1'b0) begin errors++;
            $display("[TB] FAIL full_done_pulse: after done got done=%b busy=%b, want 0 0", obs_done_after, obs_busy_after); end
    endtask

    task automatic test_valid;
        run_job(1'b1, 1'b0, 3, 2, -2);
        checks++; if (obs_data.size() !== 2) begin errors++; $display("[TB] FAIL valid_write_count: got %0d, want 2", obs_data.size()); end
        if (obs_data.size() == 2) begin
            checks++;
            if (obs_data[0] !== 16'd3 || obs_data[1] !== 16'd5 || obs_addr[0] !== 7'd0 || obs_addr[1] !== 7'd1) begin errors++;
                $display("[TB] FAIL valid_z: got %0h@%0d %0h@%0d, want 3@0 5@1", obs_data[0], obs_addr[0], obs_data[1], obs_addr[1]); end
        end
        checks++; if (obs_cyc !== 13) begin errors++; $display("[TB] FAIL valid_done_cycle: got %0d, want 13", obs_cyc); end
        checks++; if (obs_busy_after !== 1'b0) begin errors++; $display("[TB] FAIL start_in_done: got busy=%b, want 0", obs_busy_after); end
    endtask

    task automatic test_signed;
        mem_x[0] = 8'hFF; mem_x[1] = 8'h02; mem_y[0] = 8'h03;
        run_job(1'b0, 1'b1, 2, 1, -1);
        checks++;
        if (obs_data.size() !== 2 || obs_data[0] !== 16'hFFFD || obs_data[1] !== 16'h0006) begin errors++;
            $display("[TB] FAIL signed_z: got n=%0d %0h %0h, want 2 fffd 0006", obs_data.size(), obs_data[0], obs_data[1]); end
        checks++; if (obs_cyc !== 9) begin errors++; $display("[TB] FAIL single_tap_cycles: got %0d, want 9", obs_cyc); end
        run_job(1'b0, 1'b0, 2, 1, -1);
        checks++;
        if (obs_data.size() !== 2 || obs_data[0] !== 16'h02FD || obs_data[1] !== 16'h0006) begin errors++;
            $display("[TB] FAIL unsigned_z: got n=%0d %0h %0h, want 2 02fd 0006", obs_data.size(), obs_data[0], obs_data[1]); end
    endtask

    task automatic test_saturation;
        mem_x[0] = 8'd255; mem_x[1] = 8'd255; mem_y[0] = 8'd255; mem_y[1] = 8'd255;
        run_job(1'b0, 1'b0, 2, 2, -1);
        checks++;
        if (obs_data.size() !== 3 || obs_data[0] !== 16'hFE01 || obs_data[1] !== 16'hFFFF || obs_data[2] !== 16'hFE01) begin errors++;
            $display("[TB] FAIL sat_z: got n=%0d %0h %0h %0h, want 3 fe01 ffff fe01", obs_data.size(), obs_data[0], obs_data[1], obs_data[2]); end
        checks++;
        if (obs_satw.size() !== 3 || obs_satw[0] !== 1'b0 || obs_satw[2] !== 1'b1) begin errors++;
            $display("[TB] FAIL sat_timing: got first=%b third=%b, want 0 1", obs_satw[0], obs_satw[2]); end
        checks++; if (obs_sat_after !== 1'b1) begin errors++; $display("[TB] FAIL sat_sticky: got %b, want 1", obs_sat_after); end
        mem_x[0] = 8'd1; mem_y[0] = 8'd1;
        run_job(1'b0, 1'b0, 1, 1, -1);
        checks++;
        if (obs_satw.size() !== 1 || obs_satw[0] !== 1'b0 || obs_sat_done !== 1'b0) begin errors++;
            $display("[TB] FAIL sat_clear: got sat=%b at done, want 0", obs_sat_done); end
    endtask

    task automatic test_degenerate;
        int cfg [3][3] = '{'{0, 0, 4}, '{1, 2, 3}, '{0, 5, 0}};
        for (int i = 0; i < 3; i++) begin
            run_job(1'(cfg[i][0]), 1'b0, cfg[i][1], cfg[i][2], -1);
            checks++;
            if (obs_data.size() !== 0 || obs_cyc !== 2) begin errors++;
                $display("[TB] FAIL degenerate_%0d: got writes=%0d done_cycle=%0d, want 0 2", i, obs_data.size(), obs_cyc); end
        end
    endtask

    task automatic test_start_ignored;
        logic [OUT_W-1:0] want [4] = '{16'd1, 16'd3, 16'd5, 16'd3};
        mem_x[0] = 8'd1; mem_x[1] = 8'd2; mem_x[2] = 8'd3;
        mem_y[0] = 8'd1; mem_y[1] = 8'd1;
        run_job(1'b0, 1'b0, 3, 2, 7);
        checks++; if (obs_data.size() !== 4 || obs_cyc !== 21) begin errors++;
            $display("[TB] FAIL midrun_start: got writes=%0d done_cycle=%0d, want 4 21", obs_data.size(), obs_cyc); end
        for (int i = 0; i < 4 && i < obs_data.size(); i++) begin
            checks++;
            if (obs_data[i] !== want[i]) begin errors++;
                $display("[TB] FAIL midrun_start_z%0d: got %0h, want %0h", i, obs_data[i], want[i]); end
        end
    endtask

    task automatic test_reset_midrun;
        int activity = 0;
        for (int i = 0; i < 64; i++) begin mem_x[i] = 8'($urandom); mem_y[i] = 8'($urandom); end
        @(negedge clk);
        mode_i = 1'b0; signed_i = 1'b0; sizeX_i = 6'd20; sizeY_i = 6'd10; start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        repeat (30) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({memXaddr_o, memYaddr_o, memZaddr_o, dataZ_o, writeZ_o, busy_o, done_o, sat_o} !== '0) begin errors++;
            $display("[TB] FAIL midrun_reset_outputs: got x=%0h y=%0h z=%0h d=%0h w=%b b=%b dn=%b s=%b, want all 0",
                memXaddr_o, memYaddr_o, memZaddr_o, dataZ_o, writeZ_o, busy_o, done_o, sat_o); end
        start_i = 1'b1;
        repeat (2) begin @(negedge clk); if (writeZ_o || done_o || busy_o) activity++; end
        rst = 1'b0;
        start_i = 1'b0;
        repeat (3) begin @(negedge clk); if (writeZ_o || done_o || busy_o) activity++; end
        checks++; if (activity !== 0) begin errors++; $display("[TB] FAIL midrun_reset_quiet: got %0d active cycles, want 0", activity); end
        mem_x[0] = 8'd1; mem_x[1] = 8'd2; mem_x[2] = 8'd3; mem_y[0] = 8'd1; mem_y[1] = 8'd1;
        run_job(1'b0, 1'b0, 3, 2, -1);
        checks++;
        if (obs_data.size() !== 4 || obs_data[0] !== 16'd1 || obs_data[1] !== 16'd3 || obs_data[2] !== 16'd5 || obs_data[3] !== 16'd3)
            begin errors++; $display("[TB] FAIL after_reset_run: got n=%0d %0h %0h %0h %0h, want 4 1 3 5 3",
                obs_data.size(), obs_data[0], obs_data[1], obs_data[2], obs_data[3]); end
    endtask

    task automatic test_random;
        int sx, sy;
        logic md, sg;
        for (int it = 0; it < 24; it++) begin
            for (int i = 0; i < 64; i++) begin mem_x[i] = 8'($urandom); mem_y[i] = 8'($urandom); end
            md = 1'($urandom); sg = 1'($urandom);
            sx = $urandom_range(0, 12); sy = $urandom_range(0, 12);
            if (it == 0) begin sx = 63; sy = 63; md = 1'b0; sg = 1'b1; end
            if (it == 1) begin sx = 63; sy = 63; md = 1'b1; sg = 1'b0; end
            if (it == 2) begin sx = $urandom_range(1, 12); sy = 1; end
            model(md, sg, sx, sy);
            run_job(md, sg, sx, sy, (it % 3 == 0) ? 5 : -1);
            checks++; if (obs_cyc !== exp_cyc) begin errors++;
                $display("[TB] FAIL rand%0d_done_cycle: got %0d, want %0d (sx=%0d sy=%0d md=%b)", it, obs_cyc, exp_cyc, sx, sy, md); end
            checks++; if (obs_data.size() !== exp_data.size()) begin errors++;
                $display("[TB] FAIL rand%0d_write_count: got %0d, want %0d", it, obs_data.size(), exp_data.size()); end
            for (int i = 0; i < exp_data.size() && i < obs_data.size(); i++) begin
                checks++;
                if (obs_addr[i] !== 7'(i) || obs_data[i] !== exp_data[i]) begin errors++;
                    $display("[TB] FAIL rand%0d_z%0d: got %0h@%0d, want %0h@%0d", it, i, obs_data[i], obs_addr[i], exp_data[i], i); end
            end
            checks++; if (obs_sat_done !== exp_sat) begin errors++;
                $display("[TB] FAIL rand%0d_sat: got %b, want %b", it, obs_sat_done, exp_sat); end
            checks++; if (obs_busy_bad !== 1'b0) begin errors++; $display("[TB] FAIL rand%0d_busy: busy dropped before done", it); end
        end
    endtask

    initial begin
        rst = 1'b1; start_i = 1'b0; mode_i = 1'b0; signed_i = 1'b0; sizeX_i = '0; sizeY_i = '0;
        for (int i = 0; i < 64; i++) begin mem_x[i] = '0; mem_y[i] = '0; end
        test_reset;
        test_full_unsigned;
        test_valid;
        test_signed;
        test_saturation;
        test_degenerate;
        test_start_ignored;
        test_random;
        test_reset_midrun;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
